ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Parametrised PS/2 scan-code decoder. It sits between PS2_Controller (byte stream) and the game FSM.
- Decodes Set-2 make, break and E0-extended sequences through a prefix state machine.
- Maps a configurable table of NUM_KEYS scan codes to per-key press pulses, release pulses and held levels.
- Queues every decoded key event in a small FIFO for consumers that need the full event history.

Parameters:
- NUM_KEYS, 3: number of mapped keys, 1..16.
- KEY_CODES, {8'h23,8'h1B,8'h33}: packed 8*NUM_KEYS; bits [8i+7:8i] hold the make code of key i (key0=H, key1=S, key2=D).
- FIFO_DEPTH, 4: event FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 1000000: prefix abandon timeout in clock cycles; 0 disables the timeout.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- received_data  in  8  byte from PS2_Controller
- received_data_en  in  1  one-cycle strobe: received_data valid
- key_pressed  out  NUM_KEYS  one-cycle pulse on the first make of key i
- key_released  out  NUM_KEYS  one-cycle pulse on the break of a held key i
- key_held  out  NUM_KEYS  level, 1 while key i is down
- evt_valid  out  1  FIFO not empty
- evt_code  out  8  head event scan code
- evt_break  out  1  head event is a break
- evt_ext  out  1  head event was E0-prefixed
- evt_ready  in  1  consumer pop; pops when evt_valid & evt_ready
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- last_code  out  8  last non-prefix, non-control byte (debug)

Behaviour:
- One clock domain (CLOCK_50). Reset is synchronous and active-high.
- Reset state: every output 0, FSM in IDLE, FIFO empty, timeout counter 0. Reset asserted mid-sequence discards any partial prefix.
- A byte is accepted only in a cycle where received_data_en=1. Its results (pulses, key_held, FIFO push, last_code) are visible in the following cycle.
- Control bytes 00, AA, EE, FA, FC, FE and FF:
  - discarded in every state;
  - FSM returns to IDLE;
  - no event is generated and last_code is unchanged.
- FSM states and transitions on accepted bytes:
  - IDLE: E0 goes to GOT_E0. F0 goes to GOT_F0. Any other byte emits make(ext=0).
  - GOT_E0: F0 goes to GOT_E0F0. E0 stays in GOT_E0. Any other byte emits make(ext=1) and returns to IDLE.
  - GOT_F0: F0 stays in GOT_F0. E0 goes to GOT_E0 (malformed sequence; the F0 is dropped). Any other byte emits break(ext=0) and returns to IDLE.
  - GOT_E0F0: E0 goes to GOT_E0. F0 stays in GOT_E0F0. Any other byte emits break(ext=1) and returns to IDLE.
- E1 (Pause) is not supported. It is treated as an ordinary code.
- Key table matching:
  - Only ext=0 events match KEY_CODES.
  - Every table entry equal to the code is affected; duplicate entries act together.
- Make on a matched key i:
  - if key_held[i]=0: key_held[i]<=1 and key_pressed[i] pulses;
  - if already held (typematic repeat): no pulse (see Optional Feature).
- Break on a matched key i:
  - if key_held[i]=1: key_held[i]<=0 and key_released[i] pulses;
  - if not held: no effect on key outputs.
- FIFO:
  - Every emitted make or break is pushed as {code, break, ext}, including unmapped codes and repeats.
  - evt_* present the head registers; they are undefined when evt_valid=0.
  - Push and pop in the same cycle: legal at any occupancy, including full; occupancy is unchanged.
  - Full with a push and no pop: the new event is dropped and overflow<=1. overflow clears only on reset.
  - Pop while empty: ignored.
- Timeout:
  - The counter clears on every accepted byte and while in IDLE; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and no event is emitted.
  - If received_data_en coincides with expiry, the byte is processed in the current state (the byte wins).
- key_pressed and key_released are never asserted for the same key in the same cycle. At most one event is generated per cycle.

Optional Feature:
- Macro: PS2_TYPEMATIC_EN.
- Defined: a make on an already-held mapped key pulses key_pressed[i] again, giving auto-repeat for the hit key. key_held is unchanged.
- Undefined: repeat makes produce no pulse. FIFO behaviour is identical in both builds.

Test Plan:
- 33, then F0 33 -> key_pressed=001 for 1 cycle after the 33 strobe; key_held=001; then key_released=001 pulse; key_held=000; FIFO holds {33,0,0},{33,1,0}.
- 1B 1B 1B (typematic), then F0 1B -> one key_pressed[1] pulse only (three with PS2_TYPEMATIC_EN); 4 FIFO events; final key_held=000.
- E0 23, then E0 F0 23 -> no key outputs (extended does not match D); FIFO holds {23,0,1},{23,1,1}.
- F0 followed by no byte for TIMEOUT_CYCLES, then 23 -> treated as make: key_pressed[2] pulses; no break event.
- 5 makes with evt_ready=0, FIFO_DEPTH=4 -> 4 entries, overflow=1; then push and pop in the same cycle at full -> count stays 4; reset -> evt_valid=0, overflow=0.
- AA, then FA between F0 and 33 -> control bytes discarded and FSM back to IDLE; 33 then decodes as make; last_code=33.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Set-2 PS/2 scan-code decoder sitting between the PS/2 byte receiver and the
//   game FSM. A prefix state machine turns make / break / E0-extended byte
//   sequences into key events. Non-extended events are matched against a table
//   of NUM_KEYS make codes to drive per-key press/release pulses and held
//   levels. Every event (mapped or not) is also queued in a small FIFO.
//
//   Optional feature macro: PS2_TYPEMATIC_EN
//     defined   : a repeat make on an already-held mapped key pulses key_pressed again
//     undefined : repeat makes produce no pulse (FIFO behaviour identical)
//
//   Ports
//     CLOCK_50          in   system clock
//     reset             in   synchronous, active-high reset
//     received_data     in   byte from the PS/2 receiver
//     received_data_en  in   one-cycle strobe, received_data valid
//     key_pressed       out  per-key pulse on first make
//     key_released      out  per-key pulse on break of a held key
//     key_held          out  per-key level while the key is down
//     evt_valid         out  event FIFO not empty
//     evt_code          out  head event scan code
//     evt_break         out  head event is a break
//     evt_ext           out  head event was E0-prefixed
//     evt_ready         in   consumer pop (effective when evt_valid)
//     overflow          out  sticky, an event was dropped on a full FIFO
//     last_code         out  last non-prefix, non-control byte
module ps2_key_decoder #(
  parameter int unsigned           NUM_KEYS       = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h23, 8'h1B, 8'h33},
  parameter int unsigned           FIFO_DEPTH     = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_valid,
  output logic [7:0]          evt_code,
  output logic                evt_break,
  output logic                evt_ext,
  input  logic                evt_ready,
  output logic                overflow,
  output logic [7:0]          last_code
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  state_t              state_q, state_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [NUM_KEYS-1:0] key_pressed_q, key_pressed_d;
  logic [NUM_KEYS-1:0] key_released_q, key_released_d;
  logic [NUM_KEYS-1:0] key_held_q, key_held_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          last_code_q, last_code_d;
  evt_t                mem_q [FIFO_DEPTH];
  evt_t                mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic is_ctrl;
  logic ev_valid;
  logic ev_brk;
  logic ev_ext;
  logic pop;
  logic push_ok;
  logic fifo_full;

  // Keyboard control/response bytes never form part of a scan-code sequence.
  always_comb begin
    is_ctrl = 1'b0;
    case (received_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                         is_ctrl = 1'b0;
    endcase
  end

  // Prefix FSM and abandon timeout; a byte arriving at expiry is decoded in the current state.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    last_code_d = last_code_q;
    ev_valid    = 1'b0;
    ev_brk      = 1'b0;
    ev_ext      = 1'b0;
    if (received_data_en) begin
      to_cnt_d = '0;
      if (is_ctrl) begin
        state_d = S_IDLE;
      end else if (received_data == 8'hE0) begin
        state_d = S_GOT_E0;
      end else if (received_data == 8'hF0) begin
        state_d = (state_q inside {S_IDLE, S_GOT_F0}) ? S_GOT_F0 : S_GOT_E0F0;
      end else begin
        ev_valid    = 1'b1;
        ev_brk      = (state_q inside {S_GOT_F0, S_GOT_E0F0});
        ev_ext      = (state_q inside {S_GOT_E0, S_GOT_E0F0});
        state_d     = S_IDLE;
        last_code_d = received_data;
      end
    end else if (state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (TIMEOUT_CYCLES != 0) begin
      if (to_cnt_q == TO_W'(TO_LAST)) begin
        state_d  = S_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // Key table: every matching entry reacts, only non-extended events match.
  always_comb begin
    key_pressed_d  = '0;
    key_released_d = '0;
    key_held_d     = key_held_q;
    if (ev_valid && !ev_ext) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (received_data == KEY_CODES[8*i +: 8]) begin
          if (!ev_brk) begin
            if (!key_held_q[i]) begin
              key_held_d[i]    = 1'b1;
              key_pressed_d[i] = 1'b1;
            end
`ifdef PS2_TYPEMATIC_EN
            else begin
              key_pressed_d[i] = 1'b1;
            end
`endif
          end else if (key_held_q[i]) begin
            key_held_d[i]     = 1'b0;
            key_released_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Event FIFO: a pop frees a slot in the same cycle, so push+pop at full is accepted.
  always_comb begin
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = evt_ready && (count_q != '0);
    push_ok    = ev_valid && (!fifo_full || pop);
    overflow_d = overflow_q | (ev_valid && fifo_full && !pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = '{code: received_data, brk: ev_brk, ext: ev_ext};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= S_IDLE;
      to_cnt_q       <= '0;
      key_pressed_q  <= '0;
      key_released_q <= '0;
      key_held_q     <= '0;
      overflow_q     <= 1'b0;
      last_code_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      key_pressed_q  <= key_pressed_d;
      key_released_q <= key_released_d;
      key_held_q     <= key_held_d;
      overflow_q     <= overflow_d;
      last_code_q    <= last_code_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      mem_q          <= mem_d;
    end
  end

  assign key_pressed  = key_pressed_q;
  assign key_released = key_released_q;
  assign key_held     = key_held_q;
  assign overflow     = overflow_q;
  assign last_code    = last_code_q;
  assign evt_valid    = (count_q != '0);
  assign evt_code     = mem_q[rd_ptr_q].code;
  assign evt_break    = mem_q[rd_ptr_q].brk;
  assign evt_ext      = mem_q[rd_ptr_q].ext;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Bench for ps2_key_decoder: directed scenarios plus a randomized run against
//   an event-level reference model (pending-prefix flags, idle-gap counter,
//   held-key vector and an event queue).
module tb_ps2_key_decoder;

  localparam int unsigned     NK    = 3;
  localparam int unsigned     DEPTH = 4;
  localparam int unsigned     TMO   = 12;
  localparam logic [8*NK-1:0] CODES = 24'h231B33;

  logic          clk;
  logic          reset;
  logic [7:0]    received_data;
  logic          received_data_en;
  logic          evt_ready;
  logic [NK-1:0] key_pressed;
  logic [NK-1:0] key_released;
  logic [NK-1:0] key_held;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_break;
  logic          evt_ext;
  logic          overflow;
  logic [7:0]    last_code;

  ps2_key_decoder #(
    .NUM_KEYS       (NK),
    .KEY_CODES      (CODES),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_pressed      (key_pressed),
    .key_released     (key_released),
    .key_held         (key_held),
    .evt_valid        (evt_valid),
    .evt_code         (evt_code),
    .evt_break        (evt_break),
    .evt_ext          (evt_ext),
    .evt_ready        (evt_ready),
    .overflow         (overflow),
    .last_code        (last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  // Reference model state
  ev_t           m_q[$];
  logic [NK-1:0] m_held;
  logic [NK-1:0] m_pr;
  logic [NK-1:0] m_rel;
  logic          m_ovf;
  logic [7:0]    m_last;
  bit            m_ext;
  bit            m_brk;
  int            m_gap;

  int errors = 0;
  int checks = 0;

`ifdef PS2_TYPEMATIC_EN
  localparam int EXP_REPEAT_PULSES = 3;
`else
  localparam int EXP_REPEAT_PULSES = 1;
`endif

  function automatic bit is_ctrl(input logic [7:0] d);
    return d inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // One clock edge of the model. A pending prefix is forgotten once TMO or more
  // idle cycles separate it from the next byte.
  task automatic model_edge(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
    bit               pop;
    bit               emit;
    ev_t              e;
    logic [8*NK-1:0]  codes;
    logic [7:0]       kc;
    codes = CODES;
    m_pr  = '0;
    m_rel = '0;
    if (rst) begin
      m_q.delete();
      m_held = '0;
      m_ovf  = 1'b0;
      m_last = 8'h00;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_gap  = 0;
      return;
    end
    pop  = rdy && (m_q.size() > 0);
    emit = 1'b0;
    e    = '0;
    if (en) begin
      if (m_gap >= int'(TMO)) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      m_gap = 0;
      if (is_ctrl(d)) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (d == 8'hE0) begin
        m_ext = 1'b1;
        m_brk = 1'b0;
      end else if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        emit   = 1'b1;
        e      = '{code: d, brk: m_brk, ext: m_ext};
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_last = d;
      end
    end else begin
      m_gap = m_gap + 1;
    end
    if (emit && !e.ext) begin
      for (int i = 0; i < int'(NK); i++) begin
        kc = codes[8*i +: 8];
        if (kc == d) begin
          if (!e.brk) begin
            if (!m_held[i]) begin
              m_held[i] = 1'b1;
              m_pr[i]   = 1'b1;
            end else if (EXP_REPEAT_PULSES == 3) begin
              m_pr[i] = 1'b1;
            end
          end else if (m_held[i]) begin
            m_held[i] = 1'b0;
            m_rel[i]  = 1'b1;
          end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (emit) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  // Drive one cycle (called at a negedge), advance the model, return at the next negedge.
  task automatic step(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
    reset            = rst;
    received_data_en = en;
    received_data    = d;
    evt_ready        = rdy;
    model_edge(rst, en, d, rdy);
    @(negedge clk);
    reset            = 1'b0;
    received_data_en = 1'b0;
    received_data    = 8'h00;
    evt_ready        = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({key_pressed, key_released, key_held} !== '0) begin
      errors++; $display("FAIL reset_keys got=%b/%b/%b exp=0", key_pressed, key_released, key_held);
    end
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, overflow, last_code} !== '0) begin
      errors++; $display("FAIL reset_evt valid=%b code=%h brk=%b ext=%b ovf=%b last=%h exp=all 0",
                         evt_valid, evt_code, evt_break, evt_ext, overflow, last_code);
    end
    // Reset mid-sequence must discard the pending F0.
    send(8'hF0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h33);
    checks++;
    if (key_pressed !== 3'b001) begin
      errors++; $display("FAIL reset_prefix_pressed got=%b exp=001", key_pressed);
    end
    checks++;
    if ({evt_code, evt_break, evt_ext} !== {8'h33, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_prefix_evt got=%h/%b/%b exp=33/0/0", evt_code, evt_break, evt_ext);
    end
  endtask

  task automatic test_make_break();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h33);
    checks++;
    if (key_pressed !== 3'b001 || key_held !== 3'b001) begin
      errors++; $display("FAIL mb_make got pr=%b held=%b exp pr=001 held=001", key_pressed, key_held);
    end
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mb_head1 got=%b/%h/%b/%b exp=1/33/0/0", evt_valid, evt_code, evt_break, evt_ext);
    end
    checks++;
    if (last_code !== 8'h33) begin
      errors++; $display("FAIL mb_last got=%h exp=33", last_code);
    end
    idle(1);
    checks++;
    if (key_pressed !== 3'b000) begin
      errors++; $display("FAIL mb_pulse_width got=%b exp=000", key_pressed);
    end
    send(8'hF0);
    send(8'h33);
    checks++;
    if (key_released !== 3'b001 || key_held !== 3'b000 || key_pressed !== 3'b000) begin
      errors++; $display("FAIL mb_break got rel=%b held=%b pr=%b exp rel=001 held=000 pr=000",
                         key_released, key_held, key_pressed);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h33, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mb_head2 got=%b/%h/%b/%b exp=1/33/1/0", evt_valid, evt_code, evt_break, evt_ext);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL mb_empty got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_typematic();
    int np;
    int n;
    np = 0;
    n  = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(8'h1B);
      if (key_pressed[1] === 1'b1) np++;
    end
    checks++;
    if (np !== EXP_REPEAT_PULSES) begin
      errors++; $display("FAIL typ_pulses got=%0d exp=%0d", np, EXP_REPEAT_PULSES);
    end
    checks++;
    if (key_held !== 3'b010) begin
      errors++; $display("FAIL typ_held got=%b exp=010", key_held);
    end
    send(8'hF0);
    send(8'h1B);
    checks++;
    if (key_released !== 3'b010 || key_held !== 3'b000) begin
      errors++; $display("FAIL typ_break got rel=%b held=%b exp rel=010 held=000", key_released, key_held);
    end
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (evt_valid === 1'b1) n++;
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (n !== 4 || overflow !== 1'b0) begin
      errors++; $display("FAIL typ_fifo got events=%0d ovf=%b exp events=4 ovf=0", n, overflow);
    end
  endtask

  task automatic test_extended();
    logic [NK-1:0] acc;
    acc = '0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hE0); acc |= key_pressed | key_released | key_held;
    send(8'h23); acc |= key_pressed | key_released | key_held;
    send(8'hE0); acc |= key_pressed | key_released | key_held;
    send(8'hF0); acc |= key_pressed | key_released | key_held;
    send(8'h23); acc |= key_pressed | key_released | key_held;
    checks++;
    if (acc !== 3'b000) begin
      errors++; $display("FAIL ext_keys got=%b exp=000", acc);
    end
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h23, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ext_head1 got=%b/%h/%b/%b exp=1/23/0/1", evt_valid, evt_code, evt_break, evt_ext);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h23, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ext_head2 got=%b/%h/%b/%b exp=1/23/1/1", evt_valid, evt_code, evt_break, evt_ext);
    end
  endtask

  task automatic test_timeout();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // Byte arriving on the expiry cycle is still decoded with the F0 prefix.
    send(8'hF0);
    idle(int'(TMO) - 1);
    send(8'h23);
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h23, 1'b1, 1'b0} || key_released !== 3'b000) begin
      errors++; $display("FAIL to_edge got=%b/%h/%b/%b rel=%b exp=1/23/1/0 rel=000",
                         evt_valid, evt_code, evt_break, evt_ext, key_released);
    end
    drain();
    send(8'hF0);
    idle(int'(TMO));
    send(8'h23);
    checks++;
    if (key_pressed !== 3'b100 || key_held !== 3'b100) begin
      errors++; $display("FAIL to_make got pr=%b held=%b exp pr=100 held=100", key_pressed, key_held);
    end
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h23, 1'b0, 1'b0}) begin
      errors++; $display("FAIL to_evt got=%b/%h/%b/%b exp=1/23/0/0", evt_valid, evt_code, evt_break, evt_ext);
    end
    drain();
    send(8'hF0);
    send(8'h23);
    checks++;
    if (key_released !== 3'b100 || key_held !== 3'b000) begin
      errors++; $display("FAIL to_release got rel=%b held=%b exp rel=100 held=000", key_released, key_held);
    end
  endtask

  task automatic test_overflow();
    int         n;
    logic [7:0] lastc;
    n     = 0;
    lastc = 8'h00;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_pop_empty got=%b exp=0", evt_valid);
    end
    step(1'b0, 1'b1, 8'h12, 1'b1);
    checks++;
    if ({evt_valid, evt_code} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL ovf_pushpop_empty got=%b/%h exp=1/12", evt_valid, evt_code);
    end
    drain();
    for (int i = 0; i < 4; i++) send(8'h12 + 8'(i));
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_at_full got=%b exp=0", overflow);
    end
    send(8'h16);
    checks++;
    if (overflow !== 1'b1 || evt_code !== 8'h12) begin
      errors++; $display("FAIL ovf_drop got ovf=%b head=%h exp ovf=1 head=12", overflow, evt_code);
    end
    step(1'b0, 1'b1, 8'h17, 1'b1);
    checks++;
    if (evt_code !== 8'h13 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_pushpop_full got head=%h ovf=%b exp head=13 ovf=1", evt_code, overflow);
    end
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (evt_valid === 1'b1) begin
        n++;
        lastc = evt_code;
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (n !== 4 || lastc !== 8'h17) begin
      errors++; $display("FAIL ovf_count got n=%0d tail=%h exp n=4 tail=17", n, lastc);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_reset got valid=%b ovf=%b exp 0/0", evt_valid, overflow);
    end
  endtask

  task automatic test_control();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h12);
    drain();
    send(8'hAA);
    checks++;
    if (last_code !== 8'h12 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL ctl_discard got last=%h valid=%b exp last=12 valid=0", last_code, evt_valid);
    end
    send(8'hF0);
    send(8'hFA);
    send(8'h33);
    checks++;
    if (key_pressed !== 3'b001 || last_code !== 8'h33) begin
      errors++; $display("FAIL ctl_make got pr=%b last=%h exp pr=001 last=33", key_pressed, last_code);
    end
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ctl_evt got=%b/%h/%b/%b exp=1/33/0/0", evt_valid, evt_code, evt_break, evt_ext);
    end
    drain();
    send(8'hE0);
    send(8'hFE);
    send(8'h1B);
    checks++;
    if (key_pressed !== 3'b010 || evt_ext !== 1'b0) begin
      errors++; $display("FAIL ctl_e0_drop got pr=%b ext=%b exp pr=010 ext=0", key_pressed, evt_ext);
    end
  endtask

  task automatic test_random();
    logic [7:0]  pool [12] = '{8'h33, 8'h1B, 8'h23, 8'hE0, 8'hF0, 8'hE0,
                               8'hF0, 8'hAA, 8'hFA, 8'h12, 8'hE1, 8'hFF};
    int          idle_left;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [7:0]  d;
    idle_left = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 3);
      d   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      if (idle_left > 0) begin
        en = 1'b0;
        idle_left--;
      end else if ($urandom_range(0, 15) == 0) begin
        en        = 1'b0;
        idle_left = int'(TMO) - 2 + int'($urandom_range(0, 2));
      end else begin
        en = ($urandom_range(0, 1) == 1);
      end
      step(rst, en, d, rdy);
      checks++;
      if (key_pressed !== m_pr) begin
        errors++; $display("FAIL rnd_pressed cyc=%0d got=%b exp=%b", c, key_pressed, m_pr);
      end
      checks++;
      if (key_released !== m_rel) begin
        errors++; $display("FAIL rnd_released cyc=%0d got=%b exp=%b", c, key_released, m_rel);
      end
      checks++;
      if (key_held !== m_held) begin
        errors++; $display("FAIL rnd_held cyc=%0d got=%b exp=%b", c, key_held, m_held);
      end
      checks++;
      if (evt_valid !== (m_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, evt_valid, m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        checks++;
        if ({evt_code, evt_break, evt_ext} !== m_q[0]) begin
          errors++; $display("FAIL rnd_head cyc=%0d got=%h/%b/%b exp=%h/%b/%b", c,
                             evt_code, evt_break, evt_ext, m_q[0].code, m_q[0].brk, m_q[0].ext);
        end
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf);
      end
      checks++;
      if (last_code !== m_last) begin
        errors++; $display("FAIL rnd_last cyc=%0d got=%h exp=%h", c, last_code, m_last);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    received_data_en = 1'b0;
    received_data    = 8'h00;
    evt_ready        = 1'b0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_timeout();
    test_overflow();
    test_control();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1);
  end

endmodule
